// File: rtl/async_fifo_rd_ctrl_if.sv
// Read-side bus of the dual-clock FIFO: write-pointer input, read-pointer output,
// RAM read port and the output stream. "master" is the read controller and
// "slave" is its environment (write domain, RAM and consumer).
// Optional occupancy port rlevel exists only when FIFO_RD_LEVEL_EN is defined.
//
// Stream handshake: out_data carries a word whenever out_valid=1. The word is
// transferred on a rising rclk edge where out_valid=1 and out_ready=1. While
// out_valid=1 and out_ready=0, out_data is held stable. out_valid never depends
// combinationally on out_ready.
interface async_fifo_rd_ctrl_if #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
);
    logic [ASIZE:0]   wptr_gray;
    logic [ASIZE:0]   rptr_gray;
    logic [ASIZE-1:0] ram_raddr;
    logic             ram_rclken;
    logic [DSIZE-1:0] ram_rdata;
    logic             rempty;
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;
`ifdef FIFO_RD_LEVEL_EN
    logic [ASIZE:0]   rlevel;
`endif

    modport master (
        input  wptr_gray,
        input  ram_rdata,
        input  out_ready,
        output rptr_gray,
        output ram_raddr,
        output ram_rclken,
        output rempty,
        output out_valid,
        output out_data
`ifdef FIFO_RD_LEVEL_EN
        ,
        output rlevel
`endif
    );

    modport slave (
        output wptr_gray,
        output ram_rdata,
        output out_ready,
        input  rptr_gray,
        input  ram_raddr,
        input  ram_rclken,
        input  rempty,
        input  out_valid,
        input  out_data
`ifdef FIFO_RD_LEVEL_EN
        ,
        input  rlevel
`endif
    );
endinterface

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO around async_ram.
// Runs only on rclk: synchronises the Gray write pointer, keeps the binary and
// Gray read pointers, generates a registered empty flag and drives the RAM read
// port. The RAM output register doubles as the stream register, so a fetch
// issued in one cycle shows up as out_valid/out_data after the next edge.
// Optional feature macro: FIFO_RD_LEVEL_EN adds the registered rlevel output.
module async_fifo_rd_ctrl #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    async_fifo_rd_ctrl_if.master bus
);

    logic [ASIZE:0]   r_wq1;
    logic [ASIZE:0]   r_wq2;
    logic [ASIZE:0]   r_rbin;
    logic [ASIZE:0]   r_rptr_gray;
    logic             r_rempty;
    logic             r_out_valid;

    logic             w_fetch;
    logic [ASIZE:0]   w_rbin_next;
    logic [ASIZE:0]   w_rgray_next;
    logic [DSIZE-1:0] w_out_data;

    // A word is fetched when the FIFO holds data and the stream register is free
    // or being emptied in this same cycle (no bubble on accept+fetch).
    assign w_fetch      = !r_rempty && (!r_out_valid || bus.out_ready);
    assign w_rbin_next  = r_rbin + {{ASIZE{1'b0}}, w_fetch};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    // RAM read data is the stream data; it holds while ram_rclken is low.
    assign w_out_data     = bus.ram_rdata;
    assign bus.out_data   = w_out_data;
    assign bus.ram_rclken = w_fetch;
    assign bus.ram_raddr  = r_rbin[ASIZE-1:0];
    assign bus.rptr_gray  = r_rptr_gray;
    assign bus.rempty     = r_rempty;
    assign bus.out_valid  = r_out_valid;

    // Two-flop synchroniser for the Gray write pointer; only r_wq2 is consumed.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            r_wq1 <= bus.wptr_gray;
            r_wq2 <= r_wq1;
        end
    end

    // Advance read pointers on fetch; empty when the next Gray pointer meets the
    // synchronised write pointer (a stale r_wq2 can only make this pessimistic).
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rbin      <= '0;
            r_rptr_gray <= '0;
            r_rempty    <= 1'b1;
        end else begin
            r_rbin      <= w_rbin_next;
            r_rptr_gray <= w_rgray_next;
            r_rempty    <= (w_rgray_next == r_wq2);
        end
    end

    // Stream valid: set by a fetch, cleared by an accept without a new fetch.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_out_valid <= 1'b0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef FIFO_RD_LEVEL_EN
    logic [ASIZE:0] w_wq2_bin;
    logic [ASIZE:0] r_rlevel;

    // Gray to binary of the synchronised write pointer: bit i is the XOR of all
    // Gray bits at position i and above.
    always_comb begin
        w_wq2_bin = '0;
        for (int i = 0; i <= ASIZE; i++) begin
            w_wq2_bin[i] = ^(r_wq2 >> i);
        end
    end

    // Words still in the RAM, not counting the one held in out_data; uses the
    // same pointer pair as the empty flag so rlevel==0 exactly when rempty=1.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            r_rlevel <= '0;
        end else begin
            r_rlevel <= w_wq2_bin - w_rbin_next;
        end
    end

    assign bus.rlevel = r_rlevel;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Testbench for async_fifo_rd_ctrl (ASIZE=4, DSIZE=8).
// Models the write side and a registered RAM; expected stream contents come
// from a queue of written words. Define FIFO_RD_LEVEL_EN to also check rlevel.
module tb_async_fifo_rd_ctrl;
    localparam int DSIZE = 8;
    localparam int ASIZE = 4;
    localparam int DEPTH = 16;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b0;

    always #5 rclk = ~rclk;

    async_fifo_rd_ctrl_if #(.DSIZE(DSIZE), .ASIZE(ASIZE)) bus();

    async_fifo_rd_ctrl #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    logic [DSIZE-1:0] mem [DEPTH];
    logic [DSIZE-1:0] exp_q [$];
    logic [ASIZE:0]   wbin;
    int               n_checks;
    int               n_fail;

    // Registered RAM read port: data updates only when the read enable is high.
    always @(posedge rclk) begin
        if (bus.ram_rclken) bus.ram_rdata <= mem[bus.ram_raddr];
    end

    function automatic logic [ASIZE:0] to_gray(input logic [ASIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [ASIZE:0] gray_to_bin(input logic [ASIZE:0] g);
        logic [ASIZE:0] b;
        b[ASIZE] = g[ASIZE];
        for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic bit fifo_full();
        logic [ASIZE:0] used;
        used = wbin - gray_to_bin(bus.rptr_gray);
        return (used >= DEPTH);
    endfunction

    // Write-side driver: store the word, record it, publish the new Gray pointer.
    task automatic push_word(input logic [DSIZE-1:0] d);
        mem[wbin[ASIZE-1:0]] = d;
        exp_q.push_back(d);
        wbin = wbin + 1'b1;
        bus.wptr_gray = to_gray(wbin);
    endtask

    task automatic test_reset();
        rrst_n = 1'b0;
        bus.out_ready = 1'b0;
        wbin = '0;
        bus.wptr_gray = '0;
        repeat (6) begin
            @(negedge rclk);
            bus.wptr_gray = 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (bus.rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %0b expected 1", bus.rempty); end
            n_checks++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
            n_checks++;
            if (bus.rptr_gray !== 5'b0) begin n_fail++; $display("FAIL reset_rptr_gray: got %0h expected 0", bus.rptr_gray); end
            n_checks++;
            if (bus.ram_rclken !== 1'b0) begin n_fail++; $display("FAIL reset_rclken: got %0b expected 0", bus.ram_rclken); end
        end
        @(negedge rclk);
        bus.wptr_gray = '0;
        @(negedge rclk);
        rrst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_word();
        logic [DSIZE-1:0] e;
        @(negedge rclk);
        bus.out_ready = 1'b1;
        push_word(8'hA5);
        for (int k = 1; k <= 4; k++) begin
            @(negedge rclk);
            #1;
            if (k < 4) begin
                n_checks++;
                if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: edge %0d got %0b expected 0", k, bus.out_valid); end
            end else begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b expected 1", bus.out_valid); end
                n_checks++;
                if (bus.out_data !== e) begin n_fail++; $display("FAIL single_data: got %0h expected %0h", bus.out_data, e); end
                n_checks++;
                if (bus.rempty !== 1'b1) begin n_fail++; $display("FAIL single_rempty: got %0b expected 1", bus.rempty); end
                n_checks++;
                if (bus.rptr_gray !== 5'b00001) begin n_fail++; $display("FAIL single_rptr_gray: got %0b expected 00001", bus.rptr_gray); end
            end
        end
        @(negedge rclk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drop: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_prefill();
        logic [DSIZE-1:0] e;
        @(negedge rclk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge rclk);
            push_word(8'(i));
        end
        repeat (6) @(negedge rclk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge rclk);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL prefill_valid: word %0d got %0b expected 1", i, bus.out_valid); end
            n_checks++;
            if (bus.out_data !== e) begin n_fail++; $display("FAIL prefill_data: word %0d got %0h expected %0h", i, bus.out_data, e); end
            n_checks++;
            if (bus.ram_rclken !== (i < 15)) begin n_fail++; $display("FAIL prefill_rclken: word %0d got %0b expected %0b", i, bus.ram_rclken, (i < 15)); end
        end
        n_checks++;
        if (bus.rempty !== 1'b1) begin n_fail++; $display("FAIL prefill_rempty_last: got %0b expected 1", bus.rempty); end
        @(negedge rclk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL prefill_no_17th_valid: got %0b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.ram_rclken !== 1'b0) begin n_fail++; $display("FAIL prefill_no_17th_fetch: got %0b expected 0", bus.ram_rclken); end
    endtask

    task automatic test_backpressure();
        logic [DSIZE-1:0] e;
        logic [ASIZE:0]   fetched;
        @(negedge rclk);
        bus.out_ready = 1'b0;
        push_word(8'hB0);
        @(negedge rclk);
        push_word(8'hB1);
        @(negedge rclk);
        push_word(8'hB2);
        repeat (6) @(negedge rclk);
        // Word0 sits in out_data, two words remain in the RAM.
        fetched = wbin - 5'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %0b expected 1", c, bus.out_valid); end
            n_checks++;
            if (bus.out_data !== exp_q[0]) begin n_fail++; $display("FAIL bp_data_frozen: cycle %0d got %0h expected %0h", c, bus.out_data, exp_q[0]); end
            n_checks++;
            if (bus.ram_rclken !== 1'b0) begin n_fail++; $display("FAIL bp_rclken: cycle %0d got %0b expected 0", c, bus.ram_rclken); end
            n_checks++;
            if (bus.ram_raddr !== fetched[ASIZE-1:0]) begin n_fail++; $display("FAIL bp_raddr: cycle %0d got %0h expected %0h", c, bus.ram_raddr, fetched[ASIZE-1:0]); end
        end
        @(negedge rclk);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge rclk);
            #1;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            n_checks++;
            if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_valid: word %0d got %0b expected 1", k, bus.out_valid); end
            n_checks++;
            if (bus.out_data !== e) begin n_fail++; $display("FAIL bp_release_data: word %0d got %0h expected %0h", k, bus.out_data, e); end
        end
        @(negedge rclk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got %0b expected 0", bus.out_valid); end
    endtask

    task automatic test_wrap();
        logic [DSIZE-1:0] e;
        logic [ASIZE:0]   prev_gray;
        logic [ASIZE:0]   prev_bin;
        logic [ASIZE:0]   cur_bin;
        int sent, received, wraps, cyc;
        sent = 0;
        received = 0;
        wraps = 0;
        cyc = 0;
        prev_gray = bus.rptr_gray;
        prev_bin = gray_to_bin(prev_gray);
        while (received < 40 && cyc < 3000) begin
            @(negedge rclk);
            cyc++;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 40 && $urandom_range(0, 2) != 0 && !fifo_full()) begin
                push_word(8'($urandom_range(0, 255)));
                sent++;
            end
            #1;
            n_checks++;
            if ($countones(bus.rptr_gray ^ prev_gray) > 1) begin n_fail++; $display("FAIL wrap_gray_step: got %0b after %0b expected at most one bit change", bus.rptr_gray, prev_gray); end
            cur_bin = gray_to_bin(bus.rptr_gray);
            if (cur_bin < prev_bin) wraps++;
            prev_gray = bus.rptr_gray;
            prev_bin = cur_bin;
            if (bus.out_valid && bus.out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                received++;
                n_checks++;
                if (bus.out_data !== e) begin n_fail++; $display("FAIL wrap_data: word %0d got %0h expected %0h", received, bus.out_data, e); end
            end
        end
        n_checks++;
        if (received != 40) begin n_fail++; $display("FAIL wrap_timeout: got %0d words expected 40", received); end
        n_checks++;
        if (wraps < 1) begin n_fail++; $display("FAIL wrap_pointer_wrap: got %0d wraps expected at least 1", wraps); end
        n_checks++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_leftover: got %0d words left expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [DSIZE-1:0] e;
        bit seen;
        @(negedge rclk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge rclk);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge rclk);
            push_word(8'(8'h60 + i));
        end
        repeat (8) @(negedge rclk);
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_valid_before: got %0b expected 1", bus.out_valid); end
        n_checks++;
        if (bus.out_data !== exp_q[0]) begin n_fail++; $display("FAIL mid_data_before: got %0h expected %0h", bus.out_data, exp_q[0]); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++;
        if (int'(bus.rlevel) != exp_q.size() - 1) begin n_fail++; $display("FAIL mid_rlevel_before: got %0d expected %0d", bus.rlevel, exp_q.size() - 1); end
`endif
        #2;
        rrst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid_async: got %0b expected 0", bus.out_valid); end
        n_checks++;
        if (bus.rempty !== 1'b1) begin n_fail++; $display("FAIL mid_rempty: got %0b expected 1", bus.rempty); end
        n_checks++;
        if (bus.ram_rclken !== 1'b0) begin n_fail++; $display("FAIL mid_rclken: got %0b expected 0", bus.ram_rclken); end
        n_checks++;
        if (bus.rptr_gray !== 5'b0) begin n_fail++; $display("FAIL mid_rptr_gray: got %0h expected 0", bus.rptr_gray); end
`ifdef FIFO_RD_LEVEL_EN
        n_checks++;
        if (bus.rlevel !== 5'd0) begin n_fail++; $display("FAIL mid_rlevel_reset: got %0d expected 0", bus.rlevel); end
`endif
        // Write side resets together with the read side.
        wbin = '0;
        bus.wptr_gray = '0;
        exp_q.delete();
        @(negedge rclk);
        rrst_n = 1'b1;
        @(negedge rclk);
        bus.out_ready = 1'b1;
        push_word(8'h3C);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge rclk);
            #1;
            if (bus.out_valid) begin
                seen = 1'b1;
                e = exp_q.pop_front();
                n_checks++;
                if (bus.out_data !== e) begin n_fail++; $display("FAIL mid_after_data: got %0h expected %0h", bus.out_data, e); end
            end
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL mid_after_timeout: got no valid word expected one within 10 cycles"); end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        bus.out_ready = 1'b0;
        bus.wptr_gray = '0;
        wbin = '0;
        test_reset();
        test_single_word();
        test_prefill();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
